// File: rtl/spi_stream_slave.sv
// spi_stream_slave
//   SPI slave that moves a continuous stream of WIDTH-bit words per chip-select
//   frame between the SPI pins and valid/ready streams in the clk domain.
//   All four SPI modes, MSB/LSB-first, underrun/overrun reporting, explicit
//   MISO output enable.
//
// Parameters
//   WIDTH  bits per word (4..32)
//   FILL   word shifted out when no tx word is available
//   SYNC   synchroniser depth on select/mclk/mosi (2..4)
//
// Ports
//   clk, reset            system clock, async active-high reset
//   cpol, cpha, lsb_first SPI mode and bit order (static while select high)
//   select, mclk, mosi    SPI pins (asynchronous)
//   miso, miso_oe         SPI data out (registered) and pad output enable
//   tx_data/valid/ready   outgoing word stream (tx_ready = consumed this cycle)
//   rx_data/valid/ready   incoming word stream (rx_valid held until accepted)
//   busy, start, done     frame active / frame start pulse / frame end pulse
//   tx_underrun           FILL was loaded instead of tx_data
//   rx_overrun            a completed word was dropped
//   partial               frame ended mid-word (pulses with done)

module spi_stream_slave #(
  parameter int                 WIDTH = 8,
  parameter logic [WIDTH-1:0]   FILL  = {WIDTH{1'b1}},
  parameter int                 SYNC  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             lsb_first,
  input  logic             select,
  input  logic             mclk,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             busy,
  output logic             start,
  output logic             done,
  output logic             tx_underrun,
  output logic             rx_overrun,
  output logic             partial
);

  localparam int             BW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0]  MSB_POS = BW'(WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers. fill_sh shifts in ones after reset so we know when the
  // select synchroniser holds a genuine post-reset pin sample.
  // ---------------------------------------------------------------------------
  logic [SYNC-1:0] sel_sh, clk_sh, dat_sh, fill_sh;
  logic            mclk_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_sh  <= '0;
      clk_sh  <= '0;
      dat_sh  <= '0;
      fill_sh <= '0;
      mclk_q  <= 1'b0;
    end else begin
      sel_sh  <= {sel_sh[SYNC-2:0], select};
      clk_sh  <= {clk_sh[SYNC-2:0], mclk};
      dat_sh  <= {dat_sh[SYNC-2:0], mosi};
      fill_sh <= {fill_sh[SYNC-2:0], 1'b1};
      mclk_q  <= clk_sh[SYNC-1];
    end
  end

  logic sel_s, mclk_s, mosi_s;
  assign sel_s  = sel_sh[SYNC-1];
  assign mclk_s = clk_sh[SYNC-1];
  assign mosi_s = dat_sh[SYNC-1];

  // ---------------------------------------------------------------------------
  // Edge classification
  // ---------------------------------------------------------------------------
  state_t           state;
  logic             armed;
  logic [BW-1:0]    bi;
  logic [WIDTH-1:0] tx_word;
  logic [WIDTH-1:0] rx_sh;

  logic rise, fall, lead, trail, active;
  logic smp, stp, start_c, stop_c, last_bit, word_done, load;

  assign rise   = mclk_s & ~mclk_q;
  assign fall   = ~mclk_s & mclk_q;
  assign lead   = cpol ? fall : rise;
  assign trail  = cpol ? rise : fall;
  assign active = (state == ACTIVE);

  // mclk edges only count inside a frame that is still selected; a select
  // fall in the same cycle wins and ends the frame.
  assign smp = active & sel_s & (cpha ? trail : lead);
  assign stp = active & sel_s & (cpha ? lead  : trail);

  // armed blocks joining a frame that was already running when reset released
  assign start_c   = ~active & armed & sel_s;
  assign stop_c    = active & ~sel_s;
  assign last_bit  = (bi == MSB_POS);
  assign word_done = smp & last_bit;
  assign load      = start_c | word_done;

  // Handshake completes in the cycle the word is latched.
  assign tx_ready  = load & tx_valid;

  logic [BW-1:0]    pos;
  logic [WIDTH-1:0] ld_word;
  logic [WIDTH-1:0] rx_word;

  assign pos     = lsb_first ? bi : (MSB_POS - bi);
  assign ld_word = tx_valid ? tx_data : FILL;

  // Received word including the bit being sampled this cycle.
  always_comb begin
    rx_word      = rx_sh;
    rx_word[pos] = mosi_s;
  end

  // ---------------------------------------------------------------------------
  // Frame FSM and datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      armed       <= 1'b0;
      bi          <= '0;
      tx_word     <= '0;
      rx_sh       <= '0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
      start       <= 1'b0;
      done        <= 1'b0;
      partial     <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      start       <= 1'b0;
      done        <= 1'b0;
      partial     <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;

      if (fill_sh[SYNC-1] & ~sel_s)
        armed <= 1'b1;

      if (load) begin
        tx_word     <= ld_word;
        tx_underrun <= ~tx_valid;
      end

      // rx delivery; a pending word blocks a new one unless it is being
      // accepted in this very cycle.
      if (word_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_word;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_c) begin
            state   <= ACTIVE;
            busy    <= 1'b1;
            start   <= 1'b1;
            bi      <= '0;
            rx_sh   <= '0;
            miso    <= ld_word[lsb_first ? '0 : MSB_POS];
            miso_oe <= 1'b1;
          end
        end
        ACTIVE: begin
          if (stop_c) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            partial <= (bi != '0);
            miso_oe <= 1'b0;
            bi      <= '0;
          end else if (smp) begin
            rx_sh <= rx_word;
            bi    <= last_bit ? '0 : bi + BW'(1);
          end else if (stp) begin
            miso <= tx_word[pos];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_stream_slave.sv
module tb_spi_stream_slave;
  localparam int W = 8;
  localparam int SYNC = 2;
  localparam int HALF = 8;
  localparam logic [W-1:0] FILLV = '1;

  logic clk = 1'b0;
  logic reset, cpol, cpha, lsb_first, select, mclk, mosi;
  logic miso, miso_oe, tx_valid, tx_ready, rx_valid, rx_ready;
  logic busy, start, done, tx_underrun, rx_overrun, partial;
  logic [W-1:0] tx_data, rx_data;

  always #5 clk = ~clk;

  spi_stream_slave #(.WIDTH(W), .FILL(FILLV), .SYNC(SYNC)) dut (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .select(select), .mclk(mclk), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .start(start), .done(done), .tx_underrun(tx_underrun),
    .rx_overrun(rx_overrun), .partial(partial)
  );

  int total = 0, bad = 0;
  int n_start, n_done, n_part, n_txr, n_unr, n_ovr;
  logic [W-1:0] txq[$];
  logic [W-1:0] rxq[$];
  logic rdy_seen = 1'b0;

  logic [W-1:0] mw[4];
  logic [W-1:0] cap[4];
  int samp_w, samp_i;
  event ev_samp;

  // pulse counters and rx consumer, sampled mid-cycle
  always @(negedge clk) begin
    if (start) n_start++;
    if (done) n_done++;
    if (partial) n_part++;
    if (tx_ready) n_txr++;
    if (tx_underrun) n_unr++;
    if (rx_overrun) n_ovr++;
    rdy_seen = tx_ready;
    if (rx_valid && rx_ready) rxq.push_back(rx_data);
  end

  // tx producer: presents the queue head, pops on a completed handshake
  initial begin
    tx_valid = 1'b0;
    tx_data = '0;
    forever begin
      @(posedge clk);
      if (rdy_seen && txq.size() > 0) void'(txq.pop_front());
      #2;
      tx_valid = (txq.size() > 0);
      tx_data = (txq.size() > 0) ? txq[0] : '0;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: timeout reached, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clr();
    n_start = 0; n_done = 0; n_part = 0; n_txr = 0; n_unr = 0; n_ovr = 0;
    rxq.delete();
  endtask

  // SPI master: shifts nw words of mw, captures miso into cap (logical bit
  // order), stops early after stop_after bits.
  task automatic frame(input bit cp, input bit ch, input bit lsb, input int nw, input int stop_after);
    int nb, p;
    nb = 0;
    cpol = cp; cpha = ch; lsb_first = lsb; mclk = cp;
    tick(4);
    select = 1'b1;
    tick(8);
    for (int w = 0; w < nw; w++) begin
      cap[w] = '0;
      for (int i = 0; i < W; i++) begin
        if (nb >= stop_after) continue;
        p = lsb ? i : W - 1 - i;
        if (!ch) begin
          mosi = mw[w][p];
          tick(HALF);
          mclk = ~cp;
          cap[w][p] = miso;
          samp_w = w; samp_i = i; ->ev_samp;
          tick(HALF);
          mclk = cp;
        end else begin
          mclk = ~cp;
          mosi = mw[w][p];
          tick(HALF);
          mclk = cp;
          cap[w][p] = miso;
          samp_w = w; samp_i = i; ->ev_samp;
          tick(HALF);
        end
        nb++;
      end
    end
    tick(HALF);
    select = 1'b0;
    tick(8);
  endtask

  typedef struct {
    bit cp, ch, lsb;
    int avail;
    logic [W-1:0] txw, mwd, emiso, erx;
    int etxr, eunr;
  } vec_t;

  vec_t vt[6];

  bit rcp, rch, rlsb;
  int rnw, rav;
  logic [W-1:0] tw[4];
  logic [W-1:0] ew;

  initial begin
    vt[0] = '{0, 0, 0, 1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1, 1};
    vt[1] = '{0, 1, 0, 0, 8'h00, 8'h81, 8'hFF, 8'h81, 0, 2};
    vt[2] = '{1, 0, 1, 1, 8'h01, 8'h80, 8'h01, 8'h80, 1, 1};
    vt[3] = '{1, 1, 1, 1, 8'h96, 8'h5A, 8'h96, 8'h5A, 1, 1};
    vt[4] = '{0, 0, 1, 0, 8'h00, 8'h0F, 8'hFF, 8'h0F, 0, 2};
    vt[5] = '{1, 0, 0, 1, 8'h7E, 8'hE7, 8'h7E, 8'hE7, 1, 1};

    reset = 1'b1; select = 1'b0; mclk = 1'b0; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; rx_ready = 1'b1;
    clr();
    tick(3);
    chk("reset_outputs", {22'd0, miso, miso_oe, busy, rx_valid, start, done, partial,
                          tx_underrun, rx_overrun, tx_ready}, 32'd0);
    chk("reset_rx_data", rx_data, 0);
    reset = 1'b0;
    tick(10);

    // start/done latency and first miso bit
    txq.push_back(8'hC3);
    tick(2);
    clr();
    select = 1'b1;
    for (int k = 1; k <= SYNC + 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("start_latency_%0d", k), start, (k == SYNC + 1));
    end
    chk("start_miso_oe", miso_oe, 1);
    chk("start_busy", busy, 1);
    chk("start_first_bit", miso, 1);
    tick(2);
    select = 1'b0;
    for (int k = 1; k <= SYNC + 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("done_latency_%0d", k), done, (k == SYNC + 1));
      if (k == SYNC + 1) chk("done_no_partial", partial, 0);
    end
    chk("done_miso_oe", miso_oe, 0);
    chk("short_tx_ready", n_txr, 1);
    tick(4);

    // single-word vector table
    foreach (vt[v]) begin
      if (vt[v].avail > 0) txq.push_back(vt[v].txw);
      mw[0] = vt[v].mwd;
      tick(2);
      clr();
      frame(vt[v].cp, vt[v].ch, vt[v].lsb, 1, W);
      chk($sformatf("vec%0d_miso", v), cap[0], vt[v].emiso);
      chk($sformatf("vec%0d_rx_count", v), rxq.size(), 1);
      if (rxq.size() > 0) chk($sformatf("vec%0d_rx", v), rxq[0], vt[v].erx);
      chk($sformatf("vec%0d_tx_ready", v), n_txr, vt[v].etxr);
      chk($sformatf("vec%0d_underrun", v), n_unr, vt[v].eunr);
      chk($sformatf("vec%0d_frame", v), {n_start[7:0], n_done[7:0], n_part[7:0], n_ovr[7:0]}, 32'h01010000);
    end

    // mode 3, two words
    txq.push_back(8'h12); txq.push_back(8'hBE);
    mw[0] = 8'hCA; mw[1] = 8'h01;
    tick(2); clr();
    frame(1, 1, 0, 2, 2 * W);
    chk("m3_miso0", cap[0], 8'h12);
    chk("m3_miso1", cap[1], 8'hBE);
    chk("m3_rx_count", rxq.size(), 2);
    if (rxq.size() == 2) begin
      chk("m3_rx0", rxq[0], 8'hCA);
      chk("m3_rx1", rxq[1], 8'h01);
    end
    chk("m3_tx_ready", n_txr, 2);
    chk("m3_underrun", n_unr, 1);

    // overrun: consumer stalled for two words
    rx_ready = 1'b0;
    mw[0] = 8'h11; mw[1] = 8'h22;
    tick(2); clr();
    frame(0, 0, 0, 2, 2 * W);
    chk("ovr_rx_data", rx_data, 8'h11);
    chk("ovr_rx_valid", rx_valid, 1);
    chk("ovr_count", n_ovr, 1);
    rx_ready = 1'b1;
    tick(3);
    chk("ovr_drain_count", rxq.size(), 1);
    if (rxq.size() > 0) chk("ovr_drain_word", rxq[0], 8'h11);
    chk("ovr_drain_valid", rx_valid, 0);

    // same again, but rx_ready pulsed exactly on the second completion
    rx_ready = 1'b0;
    tick(2); clr();
    fork
      frame(0, 0, 0, 2, 2 * W);
      for (int k = 0; k < 2 * W; k++) begin
        @(ev_samp);
        if (samp_w == 1 && samp_i == W - 1) begin
          tick(2);
          rx_ready = 1'b1;
          tick(1);
          rx_ready = 1'b0;
        end
      end
    join
    chk("accept_no_overrun", n_ovr, 0);
    chk("accept_rx_data", rx_data, 8'h22);
    chk("accept_rx_valid", rx_valid, 1);
    chk("accept_taken", rxq.size(), 1);
    if (rxq.size() > 0) chk("accept_taken_word", rxq[0], 8'h11);
    rx_ready = 1'b1;
    tick(3);

    // abort after 3 bits
    mw[0] = 8'hAA;
    tick(2); clr();
    frame(0, 0, 0, 1, 3);
    chk("abort_done", n_done, 1);
    chk("abort_partial", n_part, 1);
    chk("abort_no_rx", rxq.size(), 0);
    chk("abort_rx_valid", rx_valid, 0);

    // reset mid-word with a held rx word
    rx_ready = 1'b0;
    mw[0] = 8'h5C; mw[1] = 8'h00;
    tick(2); clr();
    fork
      frame(0, 0, 0, 2, 2 * W);
      for (int k = 0; k < 2 * W; k++) begin
        @(ev_samp);
        if (samp_w == 1 && samp_i == 2) begin
          chk("pre_reset_rx_valid", rx_valid, 1);
          tick(1);
          reset = 1'b1;
          #1;
          chk("rst_mid_miso_oe", miso_oe, 0);
          chk("rst_mid_busy", busy, 0);
          chk("rst_mid_rx_valid", rx_valid, 0);
          tick(2);
          reset = 1'b0;
          rx_ready = 1'b1;
          clr();
        end
      end
    join
    chk("rst_no_start", n_start, 0);
    chk("rst_no_done", n_done, 0);
    chk("rst_no_rx", rxq.size(), 0);
    chk("rst_no_tx_ready", n_txr, 0);

    // recovery on the next select rise
    txq.push_back(8'h69);
    mw[0] = 8'h96;
    tick(2); clr();
    frame(0, 0, 0, 1, W);
    chk("recover_start", n_start, 1);
    chk("recover_miso", cap[0], 8'h69);
    chk("recover_rx_count", rxq.size(), 1);
    if (rxq.size() > 0) chk("recover_rx", rxq[0], 8'h96);

    // randomized frames against the word-level model
    for (int r = 0; r < 24; r++) begin
      rcp = 1'($urandom_range(0, 1));
      rch = 1'($urandom_range(0, 1));
      rlsb = 1'($urandom_range(0, 1));
      rnw = $urandom_range(1, 3);
      rav = $urandom_range(0, rnw + 1);
      for (int k = 0; k < 4; k++) begin
        tw[k] = W'($urandom);
        mw[k] = W'($urandom);
      end
      for (int k = 0; k < rav; k++) txq.push_back(tw[k]);
      tick(2); clr();
      frame(rcp, rch, rlsb, rnw, rnw * W);
      for (int k = 0; k < rnw; k++) begin
        ew = (k < rav) ? tw[k] : FILLV;
        chk($sformatf("rand%0d_miso%0d", r, k), cap[k], ew);
      end
      chk($sformatf("rand%0d_rx_count", r), rxq.size(), rnw);
      for (int k = 0; k < rnw && k < rxq.size(); k++)
        chk($sformatf("rand%0d_rx%0d", r, k), rxq[k], mw[k]);
      chk($sformatf("rand%0d_tx_ready", r), n_txr, rav);
      chk($sformatf("rand%0d_underrun", r), n_unr, rnw + 1 - rav);
      chk($sformatf("rand%0d_frame", r), {n_start[7:0], n_done[7:0], n_part[7:0], n_ovr[7:0]}, 32'h01010000);
      txq.delete();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
